// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//
// Shares the single write port of the GPR file among three writeback
// producers: ALU, load/store unit (LSU) and multiply/divide unit (MDU).
// Each producer uses a valid/ready handshake. At most one real write is
// granted per cycle. The order is fixed (LSU > MDU > ALU), but a source
// that has waited AGE_LIMIT consecutive cycles is "starved" and beats
// every non-starved source. The winning write is registered onto the GPR
// port one cycle after the handshake.
//
// Writes to x0 (rd == 0) are accepted immediately and discarded. They
// never compete for the port.
//
// Ports:
//   reg_clk, reg_rst            clock, synchronous active-high reset
//   {alu,lsu,mdu}_wb_valid      writeback request per source
//   {alu,lsu,mdu}_wb_rd         destination register per source
//   {alu,lsu,mdu}_wb_data       result per source
//   {alu,lsu,mdu}_wb_ready      request accepted this cycle (combinational)
//   wr_data_en, rd, wr_data     registered GPR write port
//   wb_grant                    registered one-hot {mdu, lsu, alu} of current write
//   stall_pipeline              combinational: a real request is waiting

module gpr_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int AGE_LIMIT      = 4
) (
  input  logic                      reg_clk,
  input  logic                      reg_rst,

  input  logic                      alu_wb_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] alu_wb_rd,
  input  logic [DATA_WIDTH-1:0]     alu_wb_data,
  output logic                      alu_wb_ready,

  input  logic                      lsu_wb_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_wb_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_wb_data,
  output logic                      lsu_wb_ready,

  input  logic                      mdu_wb_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] mdu_wb_rd,
  input  logic [DATA_WIDTH-1:0]     mdu_wb_data,
  output logic                      mdu_wb_ready,

  output logic                      wr_data_en,
  output logic [GPR_ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [2:0]                wb_grant,
  output logic                      stall_pipeline
);

  // Bit positions of each source inside the internal source vectors.
  // They match the one-hot layout of wb_grant: {mdu, lsu, alu}.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_MDU = 2'd2
  } src_e;

  localparam int NUM_SRC = 3;

  // Age counters are 4 bits wide and saturate at the starvation limit.
  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

  logic [NUM_SRC-1:0] valid;
  logic [NUM_SRC-1:0] rd_zero;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] discard;
  logic [NUM_SRC-1:0] starved;
  logic [NUM_SRC-1:0] pool;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] ready;

  logic [3:0] age_alu;
  logic [3:0] age_lsu;
  logic [3:0] age_mdu;

  logic [GPR_ADDR_WIDTH-1:0] grant_rd;
  logic [DATA_WIDTH-1:0]     grant_data;

  // Gather the per-source request attributes into vectors. A source is
  // eligible for the port only when it targets a real register; an x0
  // request is simply discarded.
  always_comb begin
    valid   = '0;
    rd_zero = '0;

    valid[SRC_ALU] = alu_wb_valid;
    valid[SRC_LSU] = lsu_wb_valid;
    valid[SRC_MDU] = mdu_wb_valid;

    rd_zero[SRC_ALU] = (alu_wb_rd == '0);
    rd_zero[SRC_LSU] = (lsu_wb_rd == '0);
    rd_zero[SRC_MDU] = (mdu_wb_rd == '0);

    eligible = valid & ~rd_zero;
    discard  = valid & rd_zero;
  end

  // A source is starved once its counter has reached the limit while it
  // is still eligible.
  always_comb begin
    starved = '0;
    starved[SRC_ALU] = eligible[SRC_ALU] && (age_alu == AGE_MAX);
    starved[SRC_LSU] = eligible[SRC_LSU] && (age_lsu == AGE_MAX);
    starved[SRC_MDU] = eligible[SRC_MDU] && (age_mdu == AGE_MAX);
  end

  // Arbitration. If anyone is starved, only the starved sources compete;
  // otherwise every eligible source does. Within the competing pool the
  // fixed order LSU > MDU > ALU picks exactly one winner. Reset blocks
  // every grant so pending requests are never accepted during reset.
  always_comb begin
    pool  = (|starved) ? starved : eligible;
    grant = '0;

    if (pool[SRC_LSU]) begin
      grant[SRC_LSU] = 1'b1;
    end else if (pool[SRC_MDU]) begin
      grant[SRC_MDU] = 1'b1;
    end else if (pool[SRC_ALU]) begin
      grant[SRC_ALU] = 1'b1;
    end

    if (reg_rst) begin
      grant = '0;
    end
  end

  // x0 requests complete in the same cycle as any real grant, since they
  // do not use the write port.
  always_comb begin
    ready = '0;
    if (!reg_rst) begin
      ready = grant | discard;
    end
  end

  assign alu_wb_ready = ready[SRC_ALU];
  assign lsu_wb_ready = ready[SRC_LSU];
  assign mdu_wb_ready = ready[SRC_MDU];

  // Stall while any real request is left waiting this cycle. During
  // reset nothing is eligible to be serviced, so the stall is held low.
  assign stall_pipeline = !reg_rst && (|(eligible & ~ready));

  // Select the address and data of the winner for the output register.
  always_comb begin
    grant_rd   = '0;
    grant_data = '0;
    unique case (1'b1)
      grant[SRC_LSU]: begin
        grant_rd   = lsu_wb_rd;
        grant_data = lsu_wb_data;
      end
      grant[SRC_MDU]: begin
        grant_rd   = mdu_wb_rd;
        grant_data = mdu_wb_data;
      end
      grant[SRC_ALU]: begin
        grant_rd   = alu_wb_rd;
        grant_data = alu_wb_data;
      end
      default: begin
        grant_rd   = '0;
        grant_data = '0;
      end
    endcase
  end

  // Age counters. A counter clears whenever its source is granted, drops
  // valid, or targets x0, so it measures consecutive denied cycles of the
  // current request only. It saturates at the limit and stays starved
  // until the source is finally granted.
  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      age_alu <= '0;
      age_lsu <= '0;
      age_mdu <= '0;
    end else begin
      if (!eligible[SRC_ALU] || grant[SRC_ALU]) begin
        age_alu <= '0;
      end else if (age_alu != AGE_MAX) begin
        age_alu <= age_alu + 4'd1;
      end

      if (!eligible[SRC_LSU] || grant[SRC_LSU]) begin
        age_lsu <= '0;
      end else if (age_lsu != AGE_MAX) begin
        age_lsu <= age_lsu + 4'd1;
      end

      if (!eligible[SRC_MDU] || grant[SRC_MDU]) begin
        age_mdu <= '0;
      end else if (age_mdu != AGE_MAX) begin
        age_mdu <= age_mdu + 4'd1;
      end
    end
  end

  // Registered GPR write port. The enable and grant vector follow the
  // arbitration every cycle; address and data only load on a grant and
  // otherwise keep their last values. Reset drops any in-flight write.
  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      wr_data_en <= 1'b0;
      rd         <= '0;
      wr_data    <= '0;
      wb_grant   <= '0;
    end else begin
      wr_data_en <= |grant;
      wb_grant   <= grant;
      if (|grant) begin
        rd      <= grant_rd;
        wr_data <= grant_data;
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter
//
// Directed bench for gpr_wb_arbiter with AGE_LIMIT = 4. Inputs change one
// time unit after the rising edge; combinational outputs are checked one
// unit later and registered outputs reflect the previous edge at that
// point.

module tb_gpr_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          reg_clk;
  logic          reg_rst;
  logic          alu_wb_valid, lsu_wb_valid, mdu_wb_valid;
  logic [AW-1:0] alu_wb_rd, lsu_wb_rd, mdu_wb_rd;
  logic [DW-1:0] alu_wb_data, lsu_wb_data, mdu_wb_data;
  logic          alu_wb_ready, lsu_wb_ready, mdu_wb_ready;
  logic          wr_data_en;
  logic [AW-1:0] rd;
  logic [DW-1:0] wr_data;
  logic [2:0]    wb_grant;
  logic          stall_pipeline;

  int checks = 0;
  int errors = 0;

  gpr_wb_arbiter #(
    .DATA_WIDTH    (DW),
    .GPR_ADDR_WIDTH(AW),
    .AGE_LIMIT     (4)
  ) dut (
    .reg_clk       (reg_clk),
    .reg_rst       (reg_rst),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_rd     (alu_wb_rd),
    .alu_wb_data   (alu_wb_data),
    .alu_wb_ready  (alu_wb_ready),
    .lsu_wb_valid  (lsu_wb_valid),
    .lsu_wb_rd     (lsu_wb_rd),
    .lsu_wb_data   (lsu_wb_data),
    .lsu_wb_ready  (lsu_wb_ready),
    .mdu_wb_valid  (mdu_wb_valid),
    .mdu_wb_rd     (mdu_wb_rd),
    .mdu_wb_data   (mdu_wb_data),
    .mdu_wb_ready  (mdu_wb_ready),
    .wr_data_en    (wr_data_en),
    .rd            (rd),
    .wr_data       (wr_data),
    .wb_grant      (wb_grant),
    .stall_pipeline(stall_pipeline)
  );

  // 10-unit clock period.
  initial begin
    reg_clk = 1'b0;
    forever #5 reg_clk = ~reg_clk;
  end

  // Drive all three request channels at once and let the combinational
  // outputs settle before any check.
  task automatic applyStimulus(
    input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
    input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld,
    input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
    alu_wb_valid = av; alu_wb_rd = ar; alu_wb_data = ad;
    lsu_wb_valid = lv; lsu_wb_rd = lr; lsu_wb_data = ld;
    mdu_wb_valid = mv; mdu_wb_rd = mr; mdu_wb_data = md;
    #1;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to one unit after the next rising edge.
  task automatic tick();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic checkWrite(input string tag, input logic en,
                            input logic [AW-1:0] r, input logic [DW-1:0] d,
                            input logic [2:0] g);
    checkOutput({tag, ".en"},    32'(wr_data_en), 32'(en));
    checkOutput({tag, ".rd"},    32'(rd),         32'(r));
    checkOutput({tag, ".data"},  wr_data,         d);
    checkOutput({tag, ".grant"}, 32'(wb_grant),   32'(g));
  endtask

  task automatic checkReady(input string tag, input logic a, input logic l,
                            input logic m, input logic s);
    checkOutput({tag, ".alu_rdy"}, 32'(alu_wb_ready),   32'(a));
    checkOutput({tag, ".lsu_rdy"}, 32'(lsu_wb_ready),   32'(l));
    checkOutput({tag, ".mdu_rdy"}, 32'(mdu_wb_ready),   32'(m));
    checkOutput({tag, ".stall"},   32'(stall_pipeline), 32'(s));
  endtask

  initial begin
    $display("[TB] start");
    reg_rst = 1'b1;
    idle();
    tick();
    tick();

    // Reset state, with a real request present that must not be accepted.
    applyStimulus(1'b1, 5'd5, 32'h1111, 1'b1, 5'd6, 32'h2222, 1'b0, 5'd0, 32'h0);
    checkWrite("reset", 1'b0, 5'd0, 32'h0, 3'b000);
    checkReady("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    reg_rst = 1'b0;
    tick();

    // Single ALU write.
    applyStimulus(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkReady("single", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkWrite("single+1", 1'b1, 5'd5, 32'h1234, 3'b001);
    checkReady("single+1", 1'b0, 1'b0, 1'b0, 1'b0);

    // Three-way conflict: LSU, then MDU, then ALU.
    applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 5'd3, 32'hC3);
    checkReady("conf0", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd1, 32'hA1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hC3);
    checkWrite("conf1", 1'b1, 5'd2, 32'hB2, 3'b010);
    checkReady("conf1", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd1, 32'hA1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkWrite("conf2", 1'b1, 5'd3, 32'hC3, 3'b100);
    checkReady("conf2", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkWrite("conf3", 1'b1, 5'd1, 32'hA1, 3'b001);
    tick();
    checkWrite("conf_idle", 1'b0, 5'd1, 32'hA1, 3'b000);

    // Aging: ALU held on rd=7 while the LSU issues a new request each cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'(10 + k), 32'(16'h100 + k),
                    1'b0, 5'd0, 32'h0);
      checkReady($sformatf("age%0d", k), 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd14, 32'h104, 1'b0, 5'd0, 32'h0);
    checkWrite("age4.prev", 1'b1, 5'd13, 32'h103, 3'b010);
    checkReady("age4", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h104, 1'b0, 5'd0, 32'h0);
    checkWrite("age5.prev", 1'b1, 5'd7, 32'h77, 3'b001);
    checkReady("age5", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    checkWrite("age6", 1'b1, 5'd14, 32'h104, 3'b010);

    // x0 discard alongside a real LSU write.
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    checkReady("x0", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    checkWrite("x0+1", 1'b1, 5'd9, 32'h99, 3'b010);
    tick();
    checkWrite("x0+2", 1'b0, 5'd9, 32'h99, 3'b000);

    // Same destination from LSU and MDU: LSU value first, MDU value last.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hAAAA, 1'b1, 5'd4, 32'h5555);
    checkReady("same", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h5555);
    checkWrite("same+1", 1'b1, 5'd4, 32'hAAAA, 3'b010);
    checkReady("same+1", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    checkWrite("same+2", 1'b1, 5'd4, 32'h5555, 3'b100);

    // Reset mid-operation: a write is in flight when reset arrives.
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkReady("rst.pre", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    reg_rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
    checkWrite("rst.N", 1'b1, 5'd8, 32'h88, 3'b001);
    checkReady("rst.N", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkWrite("rst.N+1", 1'b0, 5'd0, 32'h0, 3'b000);
    checkReady("rst.N+1", 1'b0, 1'b0, 1'b0, 1'b0);
    reg_rst = 1'b0;
    #1;
    checkReady("rst.rel", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    checkWrite("rst.rel+1", 1'b1, 5'd6, 32'h66, 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
